mem_access_unit: RTL
====================

# mem_access_unit

Memory-stage load/store unit of the RV32IMF pipeline. It sits between the EX/MEM and MEM/WB pipeline registers. It turns a load or store in the memory stage into one transaction on a request/acknowledge data-memory port, stalling the pipeline until the access completes. For loads it registers the aligned, sign- or zero-extended `ReadDataM` that MEM/WB latches. For stores it produces byte-lane write data and byte enables.

## Interface
- `ADDR_W`, default 32: data-memory address width.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `MemReadM`  in  1  load (integer or `flw`) in the memory stage.
- `MemWriteM`  in  1  store (integer or `fsw`) in the memory stage.
- `Funct3M`  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `ALUResultM`  in  32  effective byte address.
- `WriteDataM`  in  32  store data, already selected from int/FP file.
- `mem_req`  out  1  registered request, held until `mem_ack`.
- `mem_we`  out  1  registered write strobe.
- `mem_addr`  out  ADDR_W  word address, bits[1:0] = 0.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_be`  out  4  byte enables; 0000 on reads.
- `mem_ack`  in  1  one-cycle completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  read word.
- `ReadDataM`  out  32  extended load result to MEM/WB.
- `StallM`  out  1  freezes PC, IF/ID, ID/EX, EX/MEM; MEM/WB must not advance.
- `MisalignM`  out  1  misaligned access flag, combinational.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - If (`MemReadM` | `MemWriteM`) is aligned: latch the following into output registers, then go to BUSY:
    - `mem_addr` = {addr[31:2], 2'b00}
    - `mem_we` = `MemWriteM`
    - `mem_be`
    - `mem_wdata`
    - byte offset and `Funct3M`
  - `StallM` = 1 in this cycle.
  - If neither read nor write: `StallM` = 0 and the state stays IDLE.
- **BUSY**
  - `mem_req` = 1 and `StallM` = 1.
  - On `mem_ack`:
    - for a read, register the extended data into `ReadDataM`;
    - clear `mem_req`, `mem_we`, `mem_be`;
    - go to DONE.
  - With no ack the state stays BUSY indefinitely, with outputs stable.
- **DONE**
  - `StallM` = 0, so the pipeline advances at this edge and MEM/WB captures `ReadDataM`.
  - Next state is IDLE unconditionally.
  - DONE is never re-entered for the same instruction.
- **Store lanes** (`off` = addr[1:0]):
  - sb: `wdata` = {4{d[7:0]}}, `be` = 0001<<`off`.
  - sh: `wdata` = {2{d[15:0]}}, `be` = 0011<<`off`.
  - sw: `wdata` = d, `be` = 1111.
- **Load extract**: select byte `off` or halfword `off[1]`, then sign-extend (b, h) or zero-extend (bu, hu). Word loads pass through.
- Undefined `Funct3M` encodings are treated as word.
- **Misaligned access**: h/hu with `off[0]` = 1, or w with `off` ≠ 0.
  - `MisalignM` = 1, no request is issued, `StallM` = 0, and the state stays IDLE.
  - `ReadDataM` is loaded with 0 at that edge.
- `MemReadM` and `MemWriteM` both high: treated as a store.

## Timing
- Reset values: state IDLE, `mem_req`/`mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `mem_be` 0000, `ReadDataM` 0.
  - With state IDLE, `StallM` follows the IDLE rules and `MisalignM` is combinational, so neither has a forced reset value.
- Minimum access takes 3 cycles (IDLE, BUSY with ack, DONE), which means 2 stall cycles. Each extra wait cycle adds 1.
- Reset asserted mid-access aborts immediately: `mem_req` drops asynchronously and no DONE follows.
- Back-to-back memory instructions: the second one is seen in IDLE the cycle after DONE.
- `mem_*` outputs are register-driven. `StallM` and `MisalignM` are combinational from state and inputs only, never from `mem_ack`.

## Structure
- Shared package holds:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the state encoding (`MAU_IDLE`, `MAU_BUSY`, `MAU_DONE`).
- One sub-module, `load_extend`: combinational byte/halfword select plus sign/zero extension. It is also reusable for forwarding checks.

## Test plan
- lw at addr 0x100, ack in the first BUSY cycle, `mem_rdata` 0xDEADBEEF:
  - `mem_addr` = 0x100, `be` = 0000;
  - `StallM` high for 2 cycles;
  - `ReadDataM` = 0xDEADBEEF in DONE.
- lb at 0x203, `mem_rdata` 0x80FF_1234 → 0xFFFFFF80. lbu at the same address → 0x00000080. lhu at 0x202 → 0x000080FF.
- sb at 0x101 with data 0x000000AB → `mem_wdata` = 0xABABABAB, `be` = 0010, `we` = 1. sh at 0x102 with data 0x1234 → `be` = 1100.
- lw at 0x102 → `MisalignM` = 1, `mem_req` never rises, `StallM` = 0, `ReadDataM` = 0.
- sw with ack delayed 4 cycles → `mem_req` and all `mem_*` outputs stable for 5 BUSY cycles, `StallM` high throughout, then low in DONE.
- Reset driven low in BUSY → `mem_req` 0 immediately, state IDLE; a subsequent lw completes normally.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 access
// encodings, FSM state encoding and small access-size decode helpers.
package mem_access_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        MAU_IDLE = 2'd0,
        MAU_BUSY = 2'd1,
        MAU_DONE = 2'd2
    } mau_state_e;

    // Any funct3 that is not a byte or halfword access behaves as a word access.
    function automatic logic f3_is_byte(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_BU);
    endfunction

    function automatic logic f3_is_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

    function automatic logic f3_is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        if (f3_is_byte(f3)) return 1'b0;
        if (f3_is_half(f3)) return off[0];
        return off != 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load data extraction: picks the addressed byte or halfword
// out of a read word and sign- or zero-extends it to 32 bits.
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[8*off_i +: 8];
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'h000000, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'h0000, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues one request/acknowledge transaction per
// load or store, stalls the pipeline until it completes, registers load data.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        Funct3M,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       ReadDataM,
    output logic              StallM,
    output logic              MisalignM
);

    mau_state_e        state_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic [31:0]       rdata_q;

    logic              access;
    logic [1:0]        off;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       wdata_d;
    logic [3:0]        be_d;
    logic [31:0]       load_ext;

    assign access    = MemReadM | MemWriteM;
    assign off       = ALUResultM[1:0];
    assign word_addr = {ALUResultM[ADDR_W-1:2], 2'b00};
    assign MisalignM = access & f3_is_misaligned(Funct3M, off);

    // Store lane replication and byte enables for the incoming instruction.
    always_comb begin
        if (f3_is_byte(Funct3M)) begin
            wdata_d = {4{WriteDataM[7:0]}};
            be_d    = 4'b0001 << off;
        end else if (f3_is_half(Funct3M)) begin
            wdata_d = {2{WriteDataM[15:0]}};
            be_d    = 4'b0011 << off;
        end else begin
            wdata_d = WriteDataM;
            be_d    = 4'b1111;
        end
    end

    // Stall never depends on mem_ack so there is no combinational path from memory.
    always_comb begin
        case (state_q)
            MAU_IDLE: StallM = access & ~MisalignM;
            MAU_BUSY: StallM = 1'b1;
            default:  StallM = 1'b0;
        endcase
    end

    load_extend u_load_extend (
        .word_i   (mem_rdata),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .data_o   (load_ext)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MAU_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'b0000;
            off_q   <= 2'b00;
            f3_q    <= F3_W;
            rdata_q <= '0;
        end else begin
            case (state_q)
                MAU_IDLE: begin
                    if (MisalignM) begin
                        rdata_q <= '0;
                    end else if (access) begin
                        state_q <= MAU_BUSY;
                        req_q   <= 1'b1;
                        we_q    <= MemWriteM;
                        addr_q  <= word_addr;
                        wdata_q <= wdata_d;
                        be_q    <= MemWriteM ? be_d : 4'b0000;
                        off_q   <= off;
                        f3_q    <= Funct3M;
                    end
                end
                MAU_BUSY: begin
                    if (mem_ack) begin
                        if (!we_q) rdata_q <= load_ext;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        be_q    <= 4'b0000;
                        state_q <= MAU_DONE;
                    end
                end
                default: state_q <= MAU_IDLE;
            endcase
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign ReadDataM = rdata_q;

endmodule
